// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer.
//
// Contents:
//   led_mode_t : 2-bit pattern mode. The enum also supplies the mode constants
//                MODE_ROT_L, MODE_ROT_R, MODE_PINGPONG and MODE_BLINK.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L    = 2'b00,
        MODE_ROT_R    = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_BLINK    = 2'b11
    } led_mode_t;

endpackage

// File: rtl/led_seq_prescaler.sv
// Step prescaler for the LED sequencer.
//
// Counts 0..TICKS-1 while enabled and raises tick during the last count.
// A clear returns the count to 0 on the next edge; clear wins over counting.
// While en is low the count is held.
//
// Ports:
//   sys_clk : system clock
//   sys_rst : asynchronous active-high reset
//   en      : count enable
//   clr     : synchronous clear of the count
//   tick    : high while enabled and the count is at TICKS-1
module led_seq_prescaler
    import led_seq_pkg::*;
#(
    parameter int TICKS = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    if (TICKS < 2) begin : g_ticks_check
        $error("led_seq_prescaler: TICKS must be at least 2");
    end

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en & (cnt == LAST);

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer for board status indication.
//
// A prescaler produces a step tick every TICKS = CLK_HZ/1000*STEP_MS cycles.
// On each step the lit pattern advances according to the selected mode:
// rotate left, rotate right, ping-pong, or blink all. A step_now pulse forces
// an immediate step and restarts the step period. A mode change re-seeds the
// pattern without stepping. The LED drive is registered and its polarity set
// by ACTIVE_LOW.
//
// Optional feature: define LED_SEQ_PWM_EN to gate lit LEDs with an 8-bit PWM
// (on while pwm_cnt < brightness). Without it brightness is ignored.
//
// Ports:
//   sys_clk    : system clock (sole clock)
//   sys_rst    : asynchronous active-high reset
//   en         : 1 = run, 0 = freeze prescaler, pattern and outputs
//   mode       : 00 rotate left, 01 rotate right, 10 ping-pong, 11 blink
//   step_now   : single-cycle pulse forcing an immediate step
//   brightness : PWM duty for lit LEDs (LED_SEQ_PWM_EN only)
//   led        : registered LED drive
//   step_o     : one-cycle pulse coinciding with a new stepped pattern
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LEDS     = 3,
    parameter int CLK_HZ     = 24_000_000,
    parameter int STEP_MS    = 500,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              step_now,
    input  logic [7:0]        brightness,
    output logic [N_LEDS-1:0] led,
    output logic              step_o
);

    localparam int TICKS = CLK_HZ / 1000 * STEP_MS;
    localparam logic [N_LEDS-1:0] SEED      = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] ALL_ON    = '1;
    localparam logic [N_LEDS-1:0] LED_RESET = (ACTIVE_LOW != 0) ? ~SEED : SEED;

    if (N_LEDS < 1 || N_LEDS > 32) begin : g_nleds_check
        $error("led_sequencer: N_LEDS must be in 1..32");
    end

    function automatic logic [N_LEDS-1:0] drive_level(input logic [N_LEDS-1:0] lit);
        return (ACTIVE_LOW != 0) ? ~lit : lit;
    endfunction

    // Shift plus wrap term; for N_LEDS=1 both reduce to the pattern itself.
    function automatic logic [N_LEDS-1:0] rot_left(input logic [N_LEDS-1:0] p);
        return (p << 1) | (p >> (N_LEDS - 1));
    endfunction

    function automatic logic [N_LEDS-1:0] rot_right(input logic [N_LEDS-1:0] p);
        return (p >> 1) | (p << (N_LEDS - 1));
    endfunction

    led_mode_t         mode_in;
    led_mode_t         mode_q;
    led_mode_t         mode_q_next;
    logic [N_LEDS-1:0] pattern;
    logic [N_LEDS-1:0] pattern_next;
    logic [N_LEDS-1:0] led_next;
    logic              dir;
    logic              dir_next;
    logic              mode_change;
    logic              tick;
    logic              step;
    logic              presc_clr;
    logic              lit_gate;

    assign mode_in     = led_mode_t'(mode);
    assign mode_change = en & (mode_in != mode_q);
    // A mode change swallows both the natural tick and step_now.
    assign step        = en & ~mode_change & (tick | step_now);
    assign presc_clr   = en & (mode_change | step_now);

    led_seq_prescaler #(
        .TICKS(TICKS)
    ) u_prescaler (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .en     (en),
        .clr    (presc_clr),
        .tick   (tick)
    );

`ifdef LED_SEQ_PWM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pwm_cnt <= '0;
        end else if (en) begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    assign lit_gate = (pwm_cnt < brightness);
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign lit_gate          = 1'b1;
`endif

    always_comb begin
        pattern_next = pattern;
        dir_next     = dir;
        mode_q_next  = mode_q;
        if (mode_change) begin
            pattern_next = (mode_in == MODE_BLINK) ? ALL_ON : SEED;
            dir_next     = 1'b0;
            mode_q_next  = mode_in;
        end else if (step) begin
            case (mode_q)
                MODE_ROT_L: pattern_next = rot_left(pattern);
                MODE_ROT_R: pattern_next = rot_right(pattern);
                MODE_PINGPONG: begin
                    // Reversal happens on the step leaving an end position,
                    // so each end is shown exactly once per sweep.
                    if (N_LEDS == 1) begin
                        pattern_next = pattern;
                    end else if (!dir) begin
                        if (pattern[N_LEDS-1]) begin
                            pattern_next = pattern >> 1;
                            dir_next     = 1'b1;
                        end else begin
                            pattern_next = pattern << 1;
                        end
                    end else begin
                        if (pattern[0]) begin
                            pattern_next = pattern << 1;
                            dir_next     = 1'b0;
                        end else begin
                            pattern_next = pattern >> 1;
                        end
                    end
                end
                MODE_BLINK: pattern_next = (pattern == '0) ? ALL_ON : '0;
                default:    pattern_next = pattern;
            endcase
        end
    end

    assign led_next = drive_level(pattern_next & {N_LEDS{lit_gate}});

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pattern <= SEED;
            dir     <= 1'b0;
            mode_q  <= MODE_ROT_L;
            led     <= LED_RESET;
            step_o  <= 1'b0;
        end else begin
            pattern <= pattern_next;
            dir     <= dir_next;
            mode_q  <= mode_q_next;
            step_o  <= step;
            // led is held while disabled so a running PWM cannot flicker it.
            if (en) begin
                led <= led_next;
            end
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer (N_LEDS=3, TICKS=4, active-low).
// Expected LED and step_o values come from a behavioural model that tracks
// the lit LED as an integer index, a +1/-1 direction and a cycle phase.
module tb_led_sequencer;

    localparam int N     = 3;
    localparam int TICKS = 4;

    logic         clk = 1'b0;
    logic         sys_rst = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         step_now = 1'b0;
    logic [7:0]   brightness = 8'd200;
    logic [N-1:0] led;
    logic         step_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int           m_idx;
    int           m_dir;
    int           m_phase;
    int           m_pwm;
    bit           m_on;
    logic [1:0]   m_mode;
    logic [N-1:0] m_led;
    logic         m_stepo;

    led_sequencer #(
        .N_LEDS    (N),
        .CLK_HZ    (1000),
        .STEP_MS   (4),
        .ACTIVE_LOW(1)
    ) dut (
        .sys_clk   (clk),
        .sys_rst   (sys_rst),
        .en        (en),
        .mode      (mode),
        .step_now  (step_now),
        .brightness(brightness),
        .led       (led),
        .step_o    (step_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_idx   = 0;
        m_dir   = 1;
        m_phase = 0;
        m_pwm   = 0;
        m_on    = 1'b0;
        m_mode  = 2'b00;
        m_led   = 3'b110;
        m_stepo = 1'b0;
    endtask

    task automatic model_advance();
        case (m_mode)
            2'b00: m_idx = (m_idx + 1) % N;
            2'b01: m_idx = (m_idx + N - 1) % N;
            2'b10: begin
                if (N > 1) begin
                    if (m_idx + m_dir < 0 || m_idx + m_dir > N - 1) m_dir = -m_dir;
                    m_idx = m_idx + m_dir;
                end
            end
            default: m_on = !m_on;
        endcase
    endtask

    // Applies the inputs that the next rising edge will sample.
    task automatic model_step();
        bit           gate;
        logic [N-1:0] lit;
        m_stepo = 1'b0;
        if (en) begin
            gate = 1'b1;
`ifdef LED_SEQ_PWM_EN
            gate  = (m_pwm < int'(brightness));
            m_pwm = (m_pwm + 1) % 256;
`endif
            if (mode != m_mode) begin
                m_mode  = mode;
                m_idx   = 0;
                m_dir   = 1;
                m_on    = 1'b1;
                m_phase = 0;
            end else if (step_now || m_phase == TICKS - 1) begin
                model_advance();
                m_phase = 0;
                m_stepo = 1'b1;
            end else begin
                m_phase = m_phase + 1;
            end
            if (m_mode == 2'b11) lit = m_on ? {N{1'b1}} : {N{1'b0}};
            else                 lit = N'(1) << m_idx;
            m_led = ~(gate ? lit : {N{1'b0}});
        end
    endtask

    // Advance model and DUT by one edge; outputs are then sampled 1 ns later.
    task automatic run_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3 sys_rst = 1'b1;
        #1;
        checks++;
        if (led !== 3'b110 || step_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: led=%b step_o=%b required led=110 step_o=0", led, step_o);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (led !== 3'b110 || step_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: led=%b step_o=%b required led=110 step_o=0", led, step_o);
        end
        sys_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_rotate_left();
        int steps = 0;
        en   = 1'b1;
        mode = 2'b00;
        for (int c = 1; c <= 12; c++) begin
            run_cycle();
            checks++;
            if (led !== m_led || step_o !== m_stepo) begin
                errors++;
                $display("FAIL rot_left c%0d: led=%b step_o=%b required led=%b step_o=%b",
                         c, led, step_o, m_led, m_stepo);
            end
            if (step_o) steps++;
            if (c == 4) begin
                checks++;
                if (led !== 3'b101 || step_o !== 1'b1) begin
                    errors++;
                    $display("FAIL rot_left_first: led=%b step_o=%b required led=101 step_o=1", led, step_o);
                end
            end
        end
        checks++;
        if (steps != 3 || led !== 3'b110) begin
            errors++;
            $display("FAIL rot_left_count: steps=%0d led=%b required steps=3 led=110", steps, led);
        end
    endtask

    task automatic test_pingpong();
        int steps = 0;
        int prev  = 0;
        int cur;
        mode = 2'b10;
        for (int c = 0; c < 20 * TICKS + 1; c++) begin
            run_cycle();
            checks++;
            if (led !== m_led || step_o !== m_stepo) begin
                errors++;
                $display("FAIL pingpong c%0d: led=%b step_o=%b required led=%b step_o=%b",
                         c, led, step_o, m_led, m_stepo);
            end
            if (step_o) begin
                steps++;
                cur = -1;
                for (int i = 0; i < N; i++) if (led[i] == 1'b0) cur = i;
                checks++;
                if (cur - prev != 1 && prev - cur != 1) begin
                    errors++;
                    $display("FAIL pingpong_adjacent: index %0d after %0d required a neighbour", cur, prev);
                end
                prev = cur;
            end
        end
        checks++;
        if (steps != 20) begin
            errors++;
            $display("FAIL pingpong_steps: steps=%0d required 20", steps);
        end
    endtask

    task automatic test_blink_switch();
        int wait_cycles = 0;
        mode = 2'b11;
        for (int c = 0; c < 9; c++) begin
            run_cycle();
            checks++;
            if (led !== m_led || step_o !== m_stepo) begin
                errors++;
                $display("FAIL blink c%0d: led=%b step_o=%b required led=%b step_o=%b",
                         c, led, step_o, m_led, m_stepo);
            end
        end
        run_cycle();
        run_cycle();
        mode = 2'b01;
        run_cycle();
        checks++;
        if (led !== 3'b110 || step_o !== 1'b0) begin
            errors++;
            $display("FAIL blink_to_rotr: led=%b step_o=%b required led=110 step_o=0", led, step_o);
        end
        while (wait_cycles < 8) begin
            run_cycle();
            wait_cycles++;
            if (step_o) break;
        end
        checks++;
        if (wait_cycles != TICKS || led !== 3'b011) begin
            errors++;
            $display("FAIL blink_to_rotr_next: cycles=%0d led=%b required cycles=4 led=011", wait_cycles, led);
        end
    endtask

    task automatic test_step_now_collision();
        int pulses = 0;
        mode = 2'b00;
        run_cycle();
        repeat (TICKS - 1) run_cycle();
        step_now = 1'b1;
        run_cycle();
        step_now = 1'b0;
        checks++;
        if (step_o !== 1'b1 || led !== m_led) begin
            errors++;
            $display("FAIL collide_step: led=%b step_o=%b required led=%b step_o=1", led, step_o, m_led);
        end
        for (int c = 1; c <= TICKS; c++) begin
            run_cycle();
            if (step_o) pulses++;
            checks++;
            if (step_o !== (c == TICKS) || led !== m_led) begin
                errors++;
                $display("FAIL collide_after c%0d: led=%b step_o=%b required led=%b step_o=%b",
                         c, led, step_o, m_led, c == TICKS);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL collide_pulses: pulses=%0d required 1", pulses);
        end
    endtask

    task automatic test_enable_freeze();
        logic [N-1:0] held;
        int           resume = 0;
        mode = 2'b01;
        run_cycle();
        run_cycle();
        run_cycle();
        held = led;
        en   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            run_cycle();
            checks++;
            if (led !== held || step_o !== 1'b0) begin
                errors++;
                $display("FAIL freeze c%0d: led=%b step_o=%b required led=%b step_o=0", c, led, step_o, held);
            end
        end
        en = 1'b1;
        while (resume < 8) begin
            run_cycle();
            resume++;
            if (step_o) break;
        end
        checks++;
        if (resume != 2 || led !== m_led) begin
            errors++;
            $display("FAIL freeze_resume: cycles=%0d led=%b required cycles=2 led=%b", resume, led, m_led);
        end
        run_cycle();
        #3 sys_rst = 1'b1;
        #1;
        checks++;
        if (led !== 3'b110 || step_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: led=%b step_o=%b required led=110 step_o=0", led, step_o);
        end
        @(posedge clk);
        #1 sys_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            en       = ($urandom % 10) != 0;
            step_now = ($urandom % 8) == 0;
            if ($urandom % 25 == 0) mode = 2'($urandom % 4);
            run_cycle();
            checks++;
            if (led !== m_led || step_o !== m_stepo) begin
                errors++;
                $display("FAIL random c%0d: led=%b step_o=%b required led=%b step_o=%b",
                         c, led, step_o, m_led, m_stepo);
            end
        end
        en       = 1'b1;
        step_now = 1'b0;
    endtask

`ifdef LED_SEQ_PWM_EN
    task automatic test_pwm();
        int on_cycles = 0;
        int lit_zero  = 0;
        brightness = 8'd64;
        for (int c = 0; c < 256; c++) begin
            run_cycle();
            if (led !== 3'b111) on_cycles++;
            checks++;
            if (led !== m_led) begin
                errors++;
                $display("FAIL pwm64 c%0d: led=%b required %b", c, led, m_led);
            end
        end
        checks++;
        if (on_cycles != 64) begin
            errors++;
            $display("FAIL pwm64_duty: on=%0d required 64", on_cycles);
        end
        brightness = 8'd0;
        for (int c = 0; c < 256; c++) begin
            run_cycle();
            if (led !== 3'b111) lit_zero++;
        end
        checks++;
        if (lit_zero != 0) begin
            errors++;
            $display("FAIL pwm0_off: on=%0d required 0", lit_zero);
        end
        brightness = 8'd200;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_rotate_left();
        test_pingpong();
        test_blink_switch();
        test_step_now_collision();
        test_enable_freeze();
        test_random();
`ifdef LED_SEQ_PWM_EN
        test_pwm();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern sequencer for board status indication. A prescaler derives a step tick from the system clock. On each tick, an N-bit one-hot (or all-on/all-off) pattern advances according to a run-time selectable mode. The block drives the board LEDs directly through a registered, polarity-configurable output and supersedes the fixed 3-LED rotator in new designs.

## Interface
Parameters:
- N_LEDS, 3, number of LED outputs; legal range 1..32.
- CLK_HZ, 24_000_000, sys_clk frequency in Hz.
- STEP_MS, 500, step period in ms; TICKS = CLK_HZ/1000*STEP_MS. TICKS < 2 is an elaboration error.
- ACTIVE_LOW, 1, 1 = a lit LED drives 0; 0 = a lit LED drives 1.

Ports:
- sys_clk  in  1  system clock; sole clock.
- sys_rst  in  1  asynchronous, active-high reset.
- en  in  1  1 = run; 0 = freeze prescaler and pattern, hold outputs.
- mode  in  2  00 rotate left, 01 rotate right, 10 ping-pong, 11 blink all.
- step_now  in  1  single-cycle pulse; forces an immediate step.
- brightness  in  8  PWM duty for lit LEDs (see Configuration).
- led  out  N_LEDS  registered LED drive, polarity per ACTIVE_LOW.
- step_o  out  1  one-cycle pulse marking a pattern step.

## Operation
- Internal state:
  - pattern[N_LEDS-1:0]: 1 = lit.
  - dir: 0 = up (toward MSB), 1 = down.
  - mode_q: last accepted mode.
  - cnt: prescaler, width $clog2(TICKS).
- Reset values:
  - pattern = 1 (bit 0 lit); dir = 0; mode_q = 00; cnt = 0; step_o = 0.
  - led = ACTIVE_LOW ? ~pattern : pattern. For N=3, ACTIVE_LOW=1 this is 3'b110.
- Prescaler:
  - When en=1, cnt counts 0..TICKS-1 and wraps to 0.
  - tick = en & (cnt == TICKS-1).
- Step condition: step = tick | (en & step_now).
  - step_now also clears cnt.
  - tick and step_now in the same cycle produce one step only.
- Step per mode:
  - 00: rotate left, MSB wraps to bit 0.
  - 01: rotate right, bit 0 wraps to MSB.
  - 10: shift one position in direction dir.
    - At bit N-1 while going up: move to N-2 and set dir=1.
    - At bit 0 while going down: move to bit 1 and set dir=0.
    - N=3 sequence: 001,010,100,010,001,...
  - 11: pattern toggles between all-ones and all-zeros.
- Mode change (mode != mode_q while en=1), in that same cycle:
  - pattern = 1 (or all-ones in mode 11); dir = 0; cnt = 0.
  - mode_q = mode.
  - No step is taken, and step_now is ignored.
- N_LEDS = 1: rotate and ping-pong hold the pattern at 1; blink toggles it.
- A non-one-hot pattern cannot occur outside mode 11.
- Reset asserted mid-operation returns every register to its reset value asynchronously.

## Timing
- The pattern update and the led update take effect on the same clock edge that samples step.
- step_o is high for exactly the cycle following that edge, i.e. it coincides with the new led value.
- Natural step period = TICKS cycles. After step_now, the next natural step follows TICKS cycles later.
- en deassertion takes effect on the next edge; cnt resumes from its held value.
- Mode-change re-seed: led shows the seed pattern one edge after the new mode is sampled.

## Configuration
- LED_SEQ_PWM_EN defined:
  - An 8-bit free-running PWM counter runs while en=1.
  - A lit bit drives "on" only while pwm_cnt < brightness; it drives "off" otherwise.
  - brightness=0 gives always off; 255 gives 255/256 duty.
  - The PWM counter resets to 0.
- Not defined: the brightness port is ignored and lit LEDs are always fully on.

## Structure
- Shared package led_seq_pkg holds:
  - mode constants MODE_ROT_L, MODE_ROT_R, MODE_PINGPONG, MODE_BLINK;
  - the 2-bit led_mode_t typedef.
- Sub-module led_seq_prescaler contains cnt and generates tick. It has parameter TICKS and ports sys_clk, sys_rst, en, clr, tick.
- The pattern, dir and mode logic stays in the top module.

## Test plan
Unless noted, benches use CLK_HZ=1000, STEP_MS=4 (TICKS=4), N_LEDS=3, ACTIVE_LOW=1, LED_SEQ_PWM_EN undefined.
- Reset, mode 00, en=1:
  - led = 110 during reset.
  - Then led = 101, 011, 110 on every 4th cycle.
  - step_o pulses once per step.
- Mode 10, 20 steps: lit index follows 0,1,2,1,0,1,2,...
  - Never skips or repeats an end position.
- Mode 11: led alternates 000/111 every 4 cycles.
  - Switching to mode 01 mid-period gives led=110 with no step_o.
  - The next step comes 4 cycles later.
- step_now pulsed in the same cycle as tick: exactly one step and one step_o.
  - The next step follows 4 cycles later.
- en=0 for 10 cycles mid-period: led and cnt are frozen.
  - Reset asserted asynchronously between edges forces led=110 immediately.
- With LED_SEQ_PWM_EN and brightness=64: over 256 cycles the lit LED is on for exactly 64 cycles.
  - brightness=0 keeps all LEDs at 1 (off).
